instr_mem_loader: RTL and testbench

Hardware loader for the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words (big-endian), writes them into instruction memory at consecutive word addresses, and checks a trailing XOR checksum. It holds the CPU in reset for the whole load and releases it only after a clean load. This replaces simulation-time memory preloading with a synthesizable path into the same memory.

---
 rtl/instr_mem_loader.sv | 143 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Streams big-endian bytes into the instruction memory one word at a time and verifies a trailing XOR checksum.
// Holds the CPU in reset from start acceptance until a load that ends with a matching checksum.
module instr_mem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int unsigned      LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       csum_q, csum_d;
    logic             ready_d, we_d, cpu_rst_n_d, busy_d, done_d, err_d;
    logic [31:0]      addr_d, data_d;
    logic             xfer;

    assign xfer = byte_valid_i && byte_ready_o;

    // State, datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            cpu_rst_n_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            byte_ready_o <= ready_d;
            mem_we_o     <= we_d;
            mem_addr_o   <= addr_d;
            mem_data_o   <= data_d;
            cpu_rst_n_o  <= cpu_rst_n_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            err_o        <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        we_d        = 1'b0;
        addr_d      = mem_addr_o;
        data_d      = mem_data_o;
        cpu_rst_n_d = cpu_rst_n_o;
        done_d      = 1'b0;
        err_d       = err_o;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d       = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                    idx_d       = '0;
                    bcnt_d      = '0;
                    csum_d      = '0;
                    err_d       = 1'b0;
                    cpu_rst_n_d = 1'b0;
                    state_d     = (len_i == '0) ? S_CHECK : S_RECV;
                end
            end
            S_RECV: begin
                if (xfer) begin
                    word_d = {word_q[23:0], byte_data_i};
                    csum_d = csum_q ^ byte_data_i;
                    bcnt_d = 2'(bcnt_q + 2'd1);
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = 32'({idx_q[ADDR_W-1:0], 2'b00});
                        data_d  = word_d;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = (idx_d == len_q) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                if (xfer) begin
                    err_d   = (byte_data_i != csum_q);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!err_o) cpu_rst_n_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Ready and busy are registered, so they follow the state being entered
        ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
        busy_d  = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized load sessions for instr_mem_loader, checked against a byte-stream reference model.
module tb_instr_mem_loader;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned LW     = ADDR_W + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          cpu_rst_n_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;
    logic [63:0] wq[$];

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i (byte_data_i),
        .byte_ready_o(byte_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory-side monitor: records every write strobe seen mid-cycle
    always @(negedge clk_i) if (mem_we_o) wq.push_back({mem_addr_o, mem_data_o});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"}, 32'(mem_we_o), 32'd0);
        check({tag, "_addr"}, mem_addr_o, 32'd0);
        check({tag, "_data"}, mem_data_o, 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    // Presents s[0..cnt-1]; mode 0 = always valid, 1 = every other cycle, 2 = random gaps.
    // Entered and left at a negedge; returns the number of bytes actually transferred.
    task automatic send_stream(input logic [7:0] s[$], input int cnt, input int mode,
                               input bit mid_start, output int sent);
        bit v;
        bit will;
        bit tog;
        int guard;
        sent  = 0;
        tog   = 1'b1;
        guard = 0;
        while (sent < cnt && guard < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid_i = v;
            byte_data_i  = v ? s[sent] : 8'($urandom);
            if (mid_start && sent == 3) begin
                start_i = 1'b1;
                len_i   = LW'(1);
            end else begin
                start_i = 1'b0;
            end
            will = v && byte_ready_o;
            @(posedge clk_i);
            if (will) sent++;
            @(negedge clk_i);
            guard++;
        end
        byte_valid_i = 1'b0;
        byte_data_i  = 8'($urandom);
        start_i      = 1'b0;
    endtask

    task automatic start_load(input int len, output int unsigned t0);
        @(negedge clk_i);
        start_i      = 1'b1;
        len_i        = LW'(len);
        byte_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        t0      = cyc;
    endtask

    // One full session; expectations come from the byte list, requested length and checksum alone
    task automatic run_session(input string tag, input int len, input logic [7:0] data[$],
                               input logic [7:0] cks, input int mode, input bit mid_start);
        int          n;
        logic [7:0]  stream[$];
        logic [7:0]  x;
        bit          exp_err;
        int          sent;
        int          guard;
        int unsigned t0;
        logic [31:0] w;
        n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            stream.push_back(data[i]);
            x ^= data[i];
        end
        stream.push_back(cks);
        exp_err = (cks != x);
        wq.delete();

        start_load(len, t0);
        check({tag, "_busy_at_start"}, 32'(busy_o), 32'd1);
        check({tag, "_cpu_held"}, 32'(cpu_rst_n_o), 32'd0);
        check({tag, "_err_cleared"}, 32'(err_o), 32'd0);

        send_stream(stream, stream.size(), mode, mid_start, sent);
        check({tag, "_bytes_taken"}, 32'(sent), 32'(stream.size()));

        guard = 0;
        while (!done_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check({tag, "_done_seen"}, 32'(done_o), 32'd1);
        if (mode == 0) check({tag, "_latency"}, cyc - t0 + 1, 32'(5 * n + 2));
        check({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check({tag, "_cpu_held_at_done"}, 32'(cpu_rst_n_o), 32'd0);

        @(negedge clk_i);
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_cpu_release"}, 32'(cpu_rst_n_o), 32'(!exp_err));
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
        check({tag, "_err_hold"}, 32'(err_o), 32'(exp_err));

        check({tag, "_nwrites"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
            check($sformatf("%s_addr%0d", tag, i), wq[i][63:32], 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wq[i][31:0], w);
        end
        repeat (2) @(negedge clk_i);
        check({tag, "_cpu_stable"}, 32'(cpu_rst_n_o), 32'(!exp_err));
    endtask

    initial begin
        logic [7:0]  clean[$];
        logic [7:0]  rnd[$];
        logic [7:0]  one[$];
        logic [7:0]  x;
        int          len;
        int          sent;
        int unsigned t0;

        rst_i        = 1'b1;
        start_i      = 1'b0;
        len_i        = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle_cpu_held", 32'(cpu_rst_n_o), 32'd0);

        clean = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
        run_session("clean", 2, clean, 8'h01, 0, 1'b0);
        run_session("badcks", 2, clean, 8'hFF, 0, 1'b0);
        run_session("backpr", 2, clean, 8'h01, 1, 1'b1);
        rnd.delete();
        run_session("zero", 0, rnd, 8'h00, 0, 1'b0);

        rnd.delete();
        x = 8'h00;
        for (int i = 0; i < 4 * int'(DEPTH); i++) begin
            rnd.push_back(8'($urandom));
            x ^= rnd[i];
        end
        run_session("sat", 40, rnd, x, 0, 1'b0);

        // Abort a load after six bytes, then reload from address 0
        start_load(2, t0);
        send_stream(clean, 6, 0, 1'b0, sent);
        check("midrst_sent", 32'(sent), 32'd6);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_reset_vals("midrst");
        rst_i = 1'b0;
        @(negedge clk_i);
        one = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_session("reload", 1, one, 8'h08, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rnd.delete();
            len = int'($urandom_range(0, 40));
            x   = 8'h00;
            for (int i = 0; i < 4 * len; i++) begin
                rnd.push_back(8'($urandom));
                if (i < 4 * int'(DEPTH)) x ^= rnd[i];
            end
            if ($urandom_range(0, 2) == 0) x = ~x;
            run_session($sformatf("rand%0d", k), len, rnd, x, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
